// File: rtl/stack_ram_responder.sv
// Data-RAM port responder: synchronous stack RAM plus a small memory-mapped I/O window.
// Define STACK_RAM_RDW_FORWARD_EN to return write data on a same-address RAM read-during-write.
`timescale 1ns/1ps
module stack_ram_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address_ram,
  input  logic [15:0] data_ram,
  input  logic        wren_ram,
  output logic [15:0] q_ram,
  output logic [15:0] seg1,
  output logic [15:0] seg2,
  output logic        bad_access
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [7:0] {
    IO_SEG1   = 8'h00,
    IO_SEG2   = 8'h01,
    IO_CYCLE  = 8'h02,
    IO_STATUS = 8'h03
  } io_reg_e;

  logic [15:0]           mem [DEPTH];
  logic [15:0]           cycle_cnt;
  logic                  is_ram;
  logic                  is_io;
  logic                  is_unmapped;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [7:0]            io_off;
  logic [15:0]           io_rdata;
  logic [15:0]           ram_rdata;
  logic [15:0]           rdata;
  logic                  wr_ram;
  logic                  wr_seg1;
  logic                  wr_seg2;
  logic                  wr_cycle;
  logic                  wr_status_clr;

  always_comb begin
    is_ram      = ((32'(address_ram) >> DEPTH_LOG2) == 32'd0);
    is_io       = !is_ram && (address_ram[15:8] == IO_BASE[15:8]);
    is_unmapped = !is_ram && !is_io;
    ram_idx     = address_ram[DEPTH_LOG2-1:0];
    io_off      = address_ram[7:0];
  end

  // Write strobes are gated by reset_n so a write pending while reset asserts is dropped.
  always_comb begin
    wr_ram        = 1'b0;
    wr_seg1       = 1'b0;
    wr_seg2       = 1'b0;
    wr_cycle      = 1'b0;
    wr_status_clr = 1'b0;
    if (wren_ram && reset_n) begin
      wr_ram = is_ram;
      if (is_io) begin
        case (io_off)
          IO_SEG1:   wr_seg1       = 1'b1;
          IO_SEG2:   wr_seg2       = 1'b1;
          IO_CYCLE:  wr_cycle      = 1'b1;
          IO_STATUS: wr_status_clr = data_ram[0];
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    io_rdata = '0;
    case (io_off)
      IO_SEG1:   io_rdata = seg1;
      IO_SEG2:   io_rdata = seg2;
      IO_CYCLE:  io_rdata = cycle_cnt;
      IO_STATUS: io_rdata = {15'b0, bad_access};
      default:   io_rdata = '0;
    endcase
  end

  always_comb begin
    ram_rdata = mem[ram_idx];
`ifdef STACK_RAM_RDW_FORWARD_EN
    if (wr_ram)
      ram_rdata = data_ram;
`endif
  end

  always_comb begin
    rdata = '0;
    if (is_ram)
      rdata = ram_rdata;
    else if (is_io)
      rdata = io_rdata;
  end

  always_ff @(posedge clock) begin
    if (wr_ram)
      mem[ram_idx] <= data_ram;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_ram      <= '0;
      seg1       <= '0;
      seg2       <= '0;
      cycle_cnt  <= '0;
      bad_access <= 1'b0;
    end else begin
      q_ram     <= rdata;
      cycle_cnt <= wr_cycle ? '0 : cycle_cnt + 16'd1;
      if (wr_seg1)
        seg1 <= data_ram;
      if (wr_seg2)
        seg2 <= data_ram;
      // A new unmapped access outranks a STATUS clear on the same edge.
      if (is_unmapped)
        bad_access <= 1'b1;
      else if (wr_status_clr)
        bad_access <= 1'b0;
    end
  end

endmodule

// File: doc/stack_ram_responder.md
Name: stack_ram_responder

Overview:
- Memory-side responder for the CPU's data-RAM port (address_ram / data_ram / wren_ram / q_ram).
- Provides DEPTH words of synchronous stack RAM plus a small memory-mapped I/O window: two seven-segment registers, a cycle counter and a status register.
- Registered read data has one-cycle latency, which matches the CPU's one-wait-state stack fetch.
- Instantiated beside the CPU in the top level. Drives the board SEG1/SEG2 outputs.

Parameters:
- DEPTH_LOG2, 8, log2 of the RAM word count. RAM occupies addresses 0 .. 2^DEPTH_LOG2-1.
- IO_BASE, 16'hFF00, base address of the 256-word I/O window.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- address_ram  in  16  word address from CPU.
- data_ram  in  16  write data from CPU.
- wren_ram  in  1  write enable; write occurs at any posedge where it is high.
- q_ram  out  16  registered read data.
- seg1  out  16  seven-segment register 1.
- seg2  out  16  seven-segment register 2.
- bad_access  out  1  sticky flag: access to an unmapped address.

Behaviour:
- Reset (async assert, sync release):
  - q_ram=0, seg1=0, seg2=0, cycle counter=0, bad_access=0.
  - RAM contents are not reset (undefined until written).
  - A write pending in the cycle reset asserts is dropped.
- Address decode, performed on address_ram as sampled at the posedge:
  - RAM: address < 2^DEPTH_LOG2.
  - IO: address[15:8] == IO_BASE[15:8].
  - Anything else is UNMAPPED.
- Read, every cycle, no enable:
  - At posedge k, q_ram <= value selected by the address sampled at k. The CPU sees it before edge k+1.
  - Latency is exactly 1 clock. Fully pipelined: a new address every cycle yields new data every cycle.
- Write, wren_ram=1 at posedge:
  - RAM: mem[address] <= data_ram.
  - IO: the register update listed below.
  - UNMAPPED: write dropped.
  - Repeated identical writes on consecutive cycles are legal and idempotent. The CPU holds wren for up to 3 cycles after a push.
- Read-during-write to the same RAM address: q_ram returns the OLD contents (see optional feature).
- IO map, offset = address[7:0]:
  - 0x00 SEG1: R/W.
  - 0x01 SEG2: R/W.
  - 0x02 CYCLE: read returns the 16-bit free-running counter. It increments every clock and wraps FFFF->0000. Any write clears it to 0; on that edge clear wins over increment. The read value is the counter before the edge's update.
  - 0x03 STATUS: read returns {15'b0, bad_access}. A write with data_ram[0]=1 clears bad_access.
  - Other offsets: read 0, writes ignored, not flagged.
- bad_access:
  - Set at any posedge where an UNMAPPED address is presented, read or write. Reads of UNMAPPED return 0.
  - If a STATUS clear and a new UNMAPPED access coincide, set wins. This is structurally impossible on one port but is specified for the force path.
- No combinational path from any input to any output.

Optional Feature:
- Macro: STACK_RAM_RDW_FORWARD_EN.
- Defined: read-during-write to the same RAM address returns data_ram (new data) on q_ram. This is implemented with an explicit bypass mux, not by relying on RAM inference.
- Undefined: old-data behaviour as specified above.
- IO registers are unaffected: with or without the macro, an IO read returns the value before the edge's write.

Test Plan:
- Reset: assert reset_n=0 mid-run with seg1=1234 -> q_ram, seg1, seg2, bad_access all 0 immediately (async), with no clock edge required.
- Push/pop: write 0x0005 @0, then 0x0007 @1. Present addr 1 then addr 0 on consecutive cycles -> q_ram = 0007 then 0005, each exactly one edge after its address.
- RDW, addr 0x10 = 0xAAAA: write 0x5555 @0x10 while reading 0x10 -> q_ram = AAAA (macro off) / 5555 (macro on); next-cycle read = 5555 in both builds.
- IO: write 0xBEEF @FF00 and 0x0042 @FF01 -> seg1=BEEF, seg2=0042 after one edge. Read FF00 -> q_ram=BEEF.
- Counter: write any value @FF02, then read FF02 at 10 clocks after the clear edge -> q_ram = 0x0009, after which q_ram increments by 1 per cycle. Preload 0xFFFF via force -> counter wraps to 0000.
- Error: read @0x1234 -> q_ram=0, bad_access=1 and stays 1. Write 0x0001 @FF03 -> bad_access=0 next edge. Write @0x1234 -> RAM unchanged (readback of 0x0034 unaffected), flag set.
